// File: rtl/parking_lane_arbiter_if.sv
// Lane/gate-controller handshake bundle for the parking lane arbiter.
// The master side drives lane requests and gate events; the slave side is the arbiter.
interface parking_lane_arbiter_if #(
  parameter int CNT_W = 4
);
  logic [1:0]       lane_req;
  logic             gate_done;
  logic             gate_blocked;
  logic             vehicle_exit;
  logic             ctl_arrival;
  logic [1:0]       lane_grant;
  logic [CNT_W-1:0] occupancy;
  logic             full;
  logic             timeout_err;
  logic             blocked;

  modport master (
    output lane_req, gate_done, gate_blocked, vehicle_exit,
    input  ctl_arrival, lane_grant, occupancy, full, timeout_err, blocked
  );

  modport slave (
    input  lane_req, gate_done, gate_blocked, vehicle_exit,
    output ctl_arrival, lane_grant, occupancy, full, timeout_err, blocked
  );
endinterface

// File: rtl/parking_lane_arbiter.sv
// Round-robin arbiter sharing one PIN-check/gate controller between two entry lanes,
// with lot occupancy tracking, grant timeout and a sticky blocked lock-out.
module parking_lane_arbiter #(
  parameter int NUM_SPACES = 8,
  parameter int CNT_W      = 4,
  parameter int TIMEOUT    = 64
) (
  input logic                    clk,
  input logic                    rst,
  parking_lane_arbiter_if.slave  bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DONE = 2'd2,
    BLOCKED   = 2'd3
  } state_e;

  state_e           state_q;
  logic             rr_q;
  logic [TW-1:0]    tmo_q;
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic [1:0]       grant_q;
  logic             arrival_q;
  logic             full_q;
  logic             terr_q;
  logic             blocked_q;
  logic             inc_s;
  logic             pick_s;

  // Occupancy next-state: blocked outranks gate_done, so a blocked cycle never counts an entry
  always_comb begin
    inc_s = (state_q == WAIT_DONE) && !bus.gate_blocked && bus.gate_done;
    occ_d = occ_q;
    if (inc_s && bus.vehicle_exit) begin
      occ_d = occ_q;
    end else if (inc_s && (occ_q != CNT_W'(NUM_SPACES))) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (bus.vehicle_exit && (occ_q != {CNT_W{1'b0}})) begin
      occ_d = occ_q - CNT_W'(1);
    end else begin
      occ_d = occ_q;
    end
  end

  // Lane selection: round-robin pointer only matters when both lanes request
  always_comb begin
    pick_s = 1'b0;
    if (bus.lane_req == 2'b11) begin
      pick_s = rr_q;
    end else if (bus.lane_req == 2'b10) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
  end

  // Arbitration FSM with all outputs registered alongside the state transitions
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      tmo_q     <= {TW{1'b0}};
      occ_q     <= {CNT_W{1'b0}};
      grant_q   <= 2'b00;
      arrival_q <= 1'b0;
      full_q    <= 1'b0;
      terr_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      full_q    <= (occ_d == CNT_W'(NUM_SPACES));
      arrival_q <= 1'b0;
      terr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!full_q && (bus.lane_req != 2'b00)) begin
            state_q <= GRANT;
            grant_q <= pick_s ? 2'b10 : 2'b01;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          arrival_q <= 1'b1;
          tmo_q     <= {TW{1'b0}};
          state_q   <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.gate_blocked) begin
            state_q   <= BLOCKED;
            grant_q   <= 2'b00;
            blocked_q <= 1'b1;
          end else if (bus.gate_done) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            rr_q    <= ~grant_q[1];
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            rr_q    <= ~grant_q[1];
            terr_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        BLOCKED: begin
          grant_q   <= 2'b00;
          blocked_q <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          grant_q   <= 2'b00;
          blocked_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctl_arrival = arrival_q;
  assign bus.lane_grant  = grant_q;
  assign bus.occupancy   = occ_q;
  assign bus.full        = full_q;
  assign bus.timeout_err = terr_q;
  assign bus.blocked     = blocked_q;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// Scoreboard bench for parking_lane_arbiter: a lot-level reference model queues the
// expected outputs after each clock edge and a negedge monitor compares them.
module tb_parking_lane_arbiter;

  localparam int N  = 8;
  localparam int CW = 4;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  parking_lane_arbiter_if #(.CNT_W(CW)) bus ();

  parking_lane_arbiter #(.NUM_SPACES(N), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [1:0]    grant;
    logic          arr;
    logic [CW-1:0] occ;
    logic          full;
    logic          terr;
    logic          blk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: who owns the controller, what it is doing, and cars in the lot
  int m_owner = -1;  // -1 none, else lane index
  int m_phase = 0;   // 0 free, 1 announcing arrival, 2 awaiting gate, 3 locked out
  int m_wait  = 0;   // gate-wait cycles spent so far
  int m_rr    = 0;
  int m_occ   = 0;

  task automatic model_step(input logic [1:0] req, input logic done, input logic blk,
                            input logic ext, input logic r);
    exp_t e;
    bit   entered;
    e       = '0;
    entered = 1'b0;
    if (r) begin
      m_owner = -1; m_phase = 0; m_wait = 0; m_rr = 0; m_occ = 0;
      exp_q.push_back(e);
      return;
    end
    case (m_phase)
      0: if (m_occ < N && req != 2'b00) begin
           m_owner = (req == 2'b11) ? m_rr : ((req == 2'b01) ? 0 : 1);
           m_phase = 1;
         end
      1: begin e.arr = 1'b1; m_phase = 2; m_wait = 0; end
      2: begin
           m_wait++;
           if (blk) begin
             m_phase = 3; m_owner = -1;
           end else if (done) begin
             entered = 1'b1; m_rr = 1 - m_owner; m_owner = -1; m_phase = 0;
           end else if (m_wait == TO) begin
             e.terr = 1'b1; m_rr = 1 - m_owner; m_owner = -1; m_phase = 0;
           end
         end
      default: ;
    endcase
    if (!(entered && ext)) begin
      if (entered && m_occ < N) m_occ++;
      else if (ext && m_occ > 0) m_occ--;
    end
    e.grant = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    e.occ   = CW'(m_occ);
    e.full  = (m_occ == N);
    e.blk   = (m_phase == 3);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic [1:0] req, input logic done, input logic blk,
                     input logic ext, input logic r);
    rst              = r;
    bus.lane_req     = req;
    bus.gate_done    = done;
    bus.gate_blocked = blk;
    bus.vehicle_exit = ext;
    @(posedge clk);
    model_step(req, done, blk, ext, r);
    #1;
  endtask

  task automatic expect_occ(input int want, input string name);
    checks++;
    if (bus.occupancy !== CW'(want)) begin
      errors++;
      $display("FAIL %s occupancy got %0d expected %0d", name, bus.occupancy, want);
    end
  endtask

  // Monitor: every cycle the DUT presents a fresh output vector to compare
  exp_t m_e;
  exp_t m_got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_got = {bus.lane_grant, bus.ctl_arrival, bus.occupancy, bus.full,
               bus.timeout_err, bus.blocked};
      checks++;
      if (m_got !== m_e) begin
        errors++;
        $display("FAIL outputs t=%0t got grant=%b arr=%b occ=%0d full=%b terr=%b blk=%b expected grant=%b arr=%b occ=%0d full=%b terr=%b blk=%b",
                 $time, m_got.grant, m_got.arr, m_got.occ, m_got.full, m_got.terr, m_got.blk,
                 m_e.grant, m_e.arr, m_e.occ, m_e.full, m_e.terr, m_e.blk);
      end
    end
  end

  initial begin
    bus.lane_req = 2'b00; bus.gate_done = 1'b0; bus.gate_blocked = 1'b0; bus.vehicle_exit = 1'b0;
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Single request; request drops mid-grant; gate_done on the fifth edge
    cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_occ(1, "single_entry");

    // Both lanes requesting from reset: alternation, then fill the lot
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    expect_occ(4, "alternate_four");
    for (int i = 0; i < 4; i++) begin
      cyc(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    expect_occ(8, "lot_full");
    for (int i = 0; i < 5; i++) cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_occ(7, "exit_when_full");
    cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);

    // Lane 0 owns the gate but never completes: timeout, then lane 1 is next
    for (int i = 0; i < TO + 4; i++) cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_occ(7, "timeout_keeps_occ");
    cyc(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b11, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(2'b11, 1'b1, (i < 3), (i == 10), 1'b0);
    expect_occ(6, "exit_while_blocked");
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Simultaneous entry and exit, exit at empty, reset during a gate wait
    for (int i = 0; i < 3; i++) begin
      cyc(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_occ(3, "enter_and_exit");
    for (int i = 0; i < 5; i++) cyc(2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_occ(0, "exit_at_empty");
    cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, with occasional quiet stretches long enough to time out
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] rq;
      logic       dn;
      rq = 2'($urandom_range(0, 3));
      dn = ((i % 400) < 330) && ($urandom_range(0, 3) == 0);
      cyc(rq, dn, ($urandom_range(0, 249) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 299) == 0));
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
